// File: rtl/isa_pkg.sv
// isa_pkg -- instruction-set constants shared by the front end.
//
// Contents:
//   OP_*            5-bit major opcodes carried in instr[OP_MSB:OP_LSB]
//   OP_MSB/OP_LSB   opcode field position
//   TGT_MSB         top bit of the absolute jump target field instr[TGT_MSB:0]
//   itype_e         instruction-type encoding (R=00, I=01, J1=10, J2=11)
//   opcode_of()     extracts the opcode field of a 32-bit word
//   is_jump()       true when a word is an unconditional absolute jump (OP_J)
package isa_pkg;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int TGT_MSB = 26;

    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_JAL = 5'b00010;
    localparam logic [4:0] OP_BR  = 5'b00011;
    localparam logic [4:0] OP_LD  = 5'b00100;
    localparam logic [4:0] OP_ST  = 5'b00101;

    typedef enum logic [1:0] {
        ITYPE_R  = 2'b00,
        ITYPE_I  = 2'b01,
        ITYPE_J1 = 2'b10,
        ITYPE_J2 = 2'b11
    } itype_e;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic is_jump(input logic [31:0] instr);
        return opcode_of(instr) == OP_J;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- synchronous DEPTH-entry FIFO holding fetched {pc, instr} pairs.
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries; power of two, >= 2
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-high
//   push    in   write din at the tail (ignored on flush or when full without pop)
//   pop     in   drop the head entry (ignored when empty)
//   flush   in   empty the FIFO; wins over push and pop
//   din     in   entry to write
//   head    out  oldest entry; all zeros when empty
//   count   out  number of valid entries (0..DEPTH)
//   empty   out  count == 0
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read, so the
    // array contents never matter until written, and it can map to plain RAM/flops.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    assign head  = empty ? '0 : mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage in front of the decoder.
//
// Owns the PC, drives a synchronous 1-cycle-latency imem, buffers returned
// words with their PCs in fetch_fifo and hands them to decode over valid/ready.
// A redirect replaces the PC and discards every queued and in-flight word.
//
// Optional feature (compile-time macro FETCH_JUMP_PREDECODE_EN):
//   captured OP_J words steer the PC to their absolute target directly,
//   costing one bubble; without it a later stage redirects instead.
//
// Parameters:
//   PC_W      PC / imem address width (word addressed)
//   RESET_PC  PC loaded on reset
//   DEPTH     queue entries; power of two, >= 2
// Ports:
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-high
//   imem_addr       out  current PC (registered)
//   imem_rdata      in   word for the address presented the previous cycle
//   redirect_valid  in   load redirect_pc and flush all wrong-path words
//   redirect_pc     in   redirect target
//   out_valid       out  queue non-empty
//   out_ready       in   decode accepts the head this cycle
//   out_instr       out  head word; 0 when empty
//   out_pc          out  PC of head word; 0 when empty
module fetch_unit
    import isa_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = PC_W + 32;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] req_pc_q;
    logic            req_q;

    logic            pop;
    logic            push;
    logic            issue;
    logic            jump_taken;
    logic [PC_W-1:0] jump_tgt;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credits_used;
    logic [EW-1:0]   head;

    assign pop  = out_valid & out_ready;
    assign push = req_q & ~redirect_valid;

`ifdef FETCH_JUMP_PREDECODE_EN
    assign jump_taken = push & is_jump(imem_rdata);
    assign jump_tgt   = PC_W'(imem_rdata[TGT_MSB:0]);
`else
    assign jump_taken = 1'b0;
    assign jump_tgt   = '0;
`endif

    // Queued words plus the word still in the imem pipeline, after this
    // cycle's pop. Issuing only while this is below DEPTH means a returning
    // word always has a free slot, so the queue never needs to stall imem.
    assign credits_used = {1'b0, fifo_count} + (CW+1)'(req_q) - (CW+1)'(pop);
    assign issue        = ~redirect_valid & ~jump_taken
                        & (credits_used < (CW+1)'(DEPTH));

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (jump_taken) begin
            pc_d = jump_tgt;
        end else if (issue) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            req_q <= issue;
            if (issue) req_pc_q <= pc_q;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({req_pc_q, imem_rdata}),
        .head  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign imem_addr = pc_q;
    assign out_valid = ~fifo_empty;
    assign out_pc    = head[EW-1:32];
    assign out_instr = head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A queue-based reference model tracks the PC, the outstanding imem request
// and the list of buffered words; every cycle the DUT outputs are compared
// against it, and directed scenarios additionally check the delivered PC
// sequence against fixed expectations.
module tb_fetch_unit;

    localparam int          PC_W     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_JUMP_PREDECODE_EN
    localparam bit PREDECODE = 1'b1;
`else
    localparam bit PREDECODE = 1'b0;
`endif

    logic            clock;
    logic            reset;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;

    fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction memory, 256 words, indexed by the low address bits.
    logic [31:0] mem [256];
    always @(posedge clock) imem_rdata <= mem[imem_addr[7:0]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_q[$];       // words waiting for decode, oldest first
    logic [31:0] m_pc;         // next address to request
    bit          m_req;        // a request is outstanding at imem
    logic [31:0] m_req_pc;     // address of the outstanding request
    logic [31:0] dut_deliv[$]; // PCs the DUT actually handed to decode

    function automatic bit is_j(input logic [31:0] w);
        return PREDECODE && (w[31:27] == 5'b00001);
    endfunction

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_req    = 1'b0;
        m_req_pc = '0;
        m_q.delete();
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit          pop;
        bit          cap;
        bit          jmp;
        bit          iss;
        logic [31:0] w;
        int          occ;
        pop = rdy && (m_q.size() > 0);
        cap = m_req && !rv;
        w   = mem[m_req_pc[7:0]];
        jmp = cap && is_j(w);
        occ = m_q.size() + int'(m_req) - int'(pop);
        iss = !rv && !jmp && (occ < DEPTH);
        if (pop) void'(m_q.pop_front());
        if (rv) m_q.delete();
        else if (cap) m_q.push_back('{m_req_pc, w});
        if (iss) m_req_pc = m_pc;
        m_req = iss;
        if (rv)       m_pc = rpc;
        else if (jmp) m_pc = {5'b0, w[26:0]};
        else if (iss) m_pc = m_pc + 32'd1;
    endtask

    task automatic compare_outputs();
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", out_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("out_pc", out_pc, m_q[0].pc);
            check("out_instr", out_instr, m_q[0].instr);
        end else begin
            check("out_pc_empty", out_pc, 0);
            check("out_instr_empty", out_instr, 0);
        end
    endtask

    // Called at a falling edge: check, drive this cycle's inputs, advance the model,
    // then move to the next falling edge.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        compare_outputs();
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        if (out_valid && rdy) dut_deliv.push_back(out_pc);
        model_step(rv, rpc, rdy);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic fill_identity();
        for (int i = 0; i < 256; i++) mem[i] = i;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_instr", out_instr, 0);
        check("rst_addr", imem_addr, RESET_PC);
        model_reset();
        dut_deliv.delete();
        reset = 1'b0;
    endtask

    // Streaming from reset with decode always ready: address k after k edges,
    // word k-2 at the head from edge 2 on.
    task automatic stream_body(input string tag);
        for (int k = 0; k < 8; k++) begin
            check({tag, "_addr"}, imem_addr, k);
            if (k >= 2) begin
                check({tag, "_valid"}, out_valid, 1);
                check({tag, "_pc"}, out_pc, k - 2);
                check({tag, "_instr"}, out_instr, k - 2);
            end
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    initial begin
        logic [31:0] exp6 [5];
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        fill_identity();

        // 1. plain streaming
        do_reset();
        stream_body("t1");

        // 2. backpressure from cycle 3, then release
        fill_identity();
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);
        for (int k = 3; k < 7; k++) cycle(1'b0, '0, 1'b0);
        check("t2_addr_hold", imem_addr, 3);
        check("t2_head_pc", out_pc, 1);
        check("t2_head_valid", out_valid, 1);
        for (int k = 0; k < 12; k++) cycle(1'b0, '0, 1'b1);
        check("t2_len", dut_deliv.size() >= 10, 1);
        foreach (dut_deliv[i]) check("t2_seq", dut_deliv[i], i);

        // 3. redirect to 0x40 with all credits used (one queued, one in flight)
        fill_identity();
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h40, 1'b0);
        check("t3_valid_after", out_valid, 0);
        check("t3_addr", imem_addr, 32'h40);
        cycle(1'b0, '0, 1'b1);
        check("t3_bubble", out_valid, 0);
        cycle(1'b0, '0, 1'b1);
        check("t3_valid", out_valid, 1);
        check("t3_pc", out_pc, 32'h40);
        check("t3_instr", out_instr, 32'h40);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);

        // 4. redirect in the same cycle as the pop of pc 5
        fill_identity();
        do_reset();
        for (int k = 0; k < 7; k++) cycle(1'b0, '0, 1'b1);
        check("t4_head5", out_pc, 5);
        cycle(1'b1, 32'h80, 1'b1);
        for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b1);
        check("t4_len", dut_deliv.size() >= 7, 1);
        if (dut_deliv.size() >= 7) begin
            check("t4_pc5", dut_deliv[5], 5);
            check("t4_target", dut_deliv[6], 32'h80);
        end

        // 5. reset asserted between clock edges mid-stream
        fill_identity();
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("t5_valid", out_valid, 0);
        check("t5_pc", out_pc, 0);
        check("t5_instr", out_instr, 0);
        check("t5_addr", imem_addr, RESET_PC);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        dut_deliv.delete();
        stream_body("t5");

        // 6. absolute jump at address 2 targeting 0x20
        fill_identity();
        mem[2] = 32'h0800_0020;
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1);
        exp6[0] = 0;
        exp6[1] = 1;
        exp6[2] = 2;
        exp6[3] = PREDECODE ? 32'h20 : 32'h3;
        exp6[4] = PREDECODE ? 32'h21 : 32'h4;
        check("t6_len", dut_deliv.size() >= 5, 1);
        if (dut_deliv.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("t6_seq", dut_deliv[i], exp6[i]);
        end

        // 7. PC wraps past all-ones
        fill_identity();
        do_reset();
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b1);
        check("t7_len", dut_deliv.size() >= 2, 1);
        if (dut_deliv.size() >= 2) begin
            check("t7_top", dut_deliv[0], 32'hFFFF_FFFF);
            check("t7_wrap", dut_deliv[1], 0);
        end

        // 8. random traffic against the model
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rv, rpc, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
